// File: rtl/mem_io_responder_pkg.sv
// Shared constants and address decode for the memory/IO responder.
package mem_io_responder_pkg;

  localparam logic [17:0] IO_BASE     = 18'h30000;
  localparam logic [15:0] IO_UART_OFS = 16'h0000;
  localparam logic [15:0] IO_CTRL_OFS = 16'h0004;
  localparam int unsigned IO_SEL_HI   = 17;
  localparam int unsigned IO_SEL_LO   = 16;
  localparam logic [1:0]  IO_SEL      = IO_BASE[IO_SEL_HI:IO_SEL_LO];

  typedef enum logic [1:0] {
    ACC_RAM,
    ACC_UART,
    ACC_CTRL,
    ACC_IO_OTHER
  } access_e;

  // Classify a decoded 18-bit bus address.
  function automatic access_e decode_access(input logic [17:0] a);
    if (a[IO_SEL_HI:IO_SEL_LO] != IO_SEL) return ACC_RAM;
    else if (a[15:0] == IO_UART_OFS)      return ACC_UART;
    else if (a[15:0] == IO_CTRL_OFS)      return ACC_CTRL;
    else                                  return ACC_IO_OTHER;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-wide memory bus between the memory controller and the responder.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;

  modport master (
    output mem_a, mem_wr, mem_din,
    input  mem_dout, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_wr, mem_din,
    output mem_dout, io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder_sync_byte_fifo.sv
// Synchronous circular byte FIFO; a push into a full FIFO only lands if a pop frees a slot in the same cycle.
module sync_byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[head];

  // Next occupancy, exported so the owner can register flags in step with count.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (!do_push && do_pop) count_next = count - 1'b1;
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      count <= count_next;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[tail] <= din;
  end
endmodule

// File: rtl/mem_io_responder.sv
// Target side of the byte memory bus: byte RAM plus UART/control IO window.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 17,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  mem_io_responder_if.slave   bus,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ack,
  output logic                halt,
  output logic                tx_overflow
);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] FULL_AT = (PW+1)'(TX_DEPTH - FULL_MARGIN);

  logic [7:0]           ram [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] idx;
  access_e              acc;
  logic [7:0]           dout_q;
  logic                 buf_full_q;
  logic                 unused_addr_hi;

  logic                 tx_push;
  logic                 tx_pop;
  logic [PW:0]          tx_count;
  logic [PW:0]          tx_count_next;
  logic                 tx_full;
  logic                 tx_empty;

  assign idx            = bus.mem_a[ADDR_BITS-1:0];
  assign acc            = decode_access(bus.mem_a[17:0]);
  assign unused_addr_hi = ^bus.mem_a[31:18];

  assign bus.mem_dout       = dout_q;
  assign bus.io_buffer_full = buf_full_q;

  assign tx_push  = rdy && (acc == ACC_UART) && bus.mem_wr;
  assign tx_pop   = rdy && tx_ready && !tx_empty;
  assign tx_valid = (tx_count != '0);

  sync_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (tx_push),
    .din        (bus.mem_din),
    .pop        (tx_pop),
    .dout       (tx_data),
    .count      (tx_count),
    .count_next (tx_count_next),
    .full       (tx_full),
    .empty      (tx_empty)
  );

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && rdy && (acc == ACC_RAM) && bus.mem_wr) ram[idx] <= bus.mem_din;
  end

  // Read data, rx handshake and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q      <= '0;
      buf_full_q  <= 1'b0;
      rx_ack      <= 1'b0;
      halt        <= 1'b0;
      tx_overflow <= 1'b0;
    end else if (rdy) begin
      rx_ack     <= 1'b0;
      buf_full_q <= (tx_count_next >= FULL_AT);
      unique case (acc)
        ACC_RAM: begin
          if (!bus.mem_wr) dout_q <= ram[idx];
        end
        ACC_UART: begin
          if (bus.mem_wr) begin
            if (tx_full && !tx_pop) tx_overflow <= 1'b1;
          end else begin
            dout_q <= rx_valid ? rx_data : 8'h00;
            rx_ack <= rx_valid;
          end
        end
        ACC_CTRL: begin
          if (bus.mem_wr) halt <= 1'b1;
          else            dout_q <= {7'b0, buf_full_q};
        end
        default: begin
          if (!bus.mem_wr) dout_q <= '0;
        end
      endcase
    end else begin
      rx_ack <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: queue/array reference model plus directed literal checks.
module tb_mem_io_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rx_ack;
  logic       halt;
  logic       tx_overflow;

  mem_io_responder_if bus ();

  always #5 clk = ~clk;

  mem_io_responder #(
    .ADDR_BITS   (17),
    .TX_DEPTH    (8),
    .FULL_MARGIN (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .bus         (bus.slave),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .halt        (halt),
    .tx_overflow (tx_overflow)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_ram [int];
  logic [7:0] m_q [$];
  logic [7:0] m_dout;
  bit         m_dout_known = 0;
  bit         m_live = 0;
  bit         m_ack, m_halt, m_ovf, m_full;

  task automatic model_step();
    logic [31:0] a;
    int          idx;
    bit          pop;
    bit          push;
    a    = bus.mem_a;
    push = 0;
    if (rst) begin
      m_live       = 1;
      m_dout       = 8'h00;
      m_dout_known = 1;
      m_q.delete();
      m_ack  = 0;
      m_halt = 0;
      m_ovf  = 0;
      m_full = 0;
    end else if (rdy) begin
      pop   = (m_q.size() != 0) && tx_ready;
      m_ack = 0;
      if (a[17:16] != 2'b11) begin
        idx = int'(a[16:0]);
        if (bus.mem_wr) m_ram[idx] = bus.mem_din;
        else if (m_ram.exists(idx)) begin
          m_dout = m_ram[idx];
          m_dout_known = 1;
        end else m_dout_known = 0;
      end else if (a[15:0] == 16'h0000) begin
        if (bus.mem_wr) begin
          if (m_q.size() == 8 && !pop) m_ovf = 1;
          else push = 1;
        end else begin
          m_dout = rx_valid ? rx_data : 8'h00;
          m_dout_known = 1;
          m_ack = rx_valid;
        end
      end else if (a[15:0] == 16'h0004) begin
        if (bus.mem_wr) m_halt = 1;
        else begin
          m_dout = {7'b0, m_full};
          m_dout_known = 1;
        end
      end else if (!bus.mem_wr) begin
        m_dout = 8'h00;
        m_dout_known = 1;
      end
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(bus.mem_din);
      m_full = (m_q.size() >= 6);
    end else begin
      m_ack = 0;
    end
  endtask

  task automatic compare();
    if (!m_live) return;
    if (m_dout_known) check8("mem_dout", bus.mem_dout, m_dout);
    check8("tx_valid", {7'b0, tx_valid}, {7'b0, m_q.size() != 0});
    if (m_q.size() != 0) check8("tx_data", tx_data, m_q[0]);
    check8("io_buffer_full", {7'b0, bus.io_buffer_full}, {7'b0, m_full});
    check8("rx_ack", {7'b0, rx_ack}, {7'b0, m_ack});
    check8("halt", {7'b0, halt}, {7'b0, m_halt});
    check8("tx_overflow", {7'b0, tx_overflow}, {7'b0, m_ovf});
  endtask

  // Single compare process: model advances on each edge, outputs checked 1 ns later.
  always begin
    @(posedge clk);
    model_step();
    #1;
    compare();
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] a, input bit wr, input logic [7:0] d);
    bus.mem_a   = a;
    bus.mem_wr  = wr;
    bus.mem_din = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] exp4 [4];
    logic [7:0] e;
    logic [31:0] a;
    exp4 = '{8'hA5, 8'h11, 8'h22, 8'h33};

    rst = 1'b1; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    bus.mem_a = '0; bus.mem_wr = 1'b0; bus.mem_din = '0;
    step(32'h0, 0, 8'h00);
    step(32'h0, 0, 8'h00);
    check8("rst_dout", bus.mem_dout, 8'h00);
    check8("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check8("rst_full", {7'b0, bus.io_buffer_full}, 8'h00);
    check8("rst_ack", {7'b0, rx_ack}, 8'h00);
    check8("rst_halt", {7'b0, halt}, 8'h00);
    check8("rst_ovf", {7'b0, tx_overflow}, 8'h00);
    rst = 1'b0;

    // RAM write then read, then back-to-back reads
    step(32'h0, 1, 8'h00);
    step(32'h10, 1, 8'hA5);
    step(32'h10, 0, 8'h00);
    check8("raw_a5", bus.mem_dout, 8'hA5);
    step(32'h11, 1, 8'h11);
    check8("wr_holds_dout", bus.mem_dout, 8'hA5);
    step(32'h12, 1, 8'h22);
    step(32'h13, 1, 8'h33);
    for (int i = 0; i < 4; i++) begin
      step(32'h10 + i, 0, 8'h00);
      check8("b2b_read", bus.mem_dout, exp4[i]);
    end

    // fill to threshold, then drain
    for (int i = 0; i < 6; i++) begin
      step(32'h30000, 1, 8'h50 + 8'(i));
      if (i == 4) check8("full_at5", {7'b0, bus.io_buffer_full}, 8'h00);
      if (i == 5) check8("full_at6", {7'b0, bus.io_buffer_full}, 8'h01);
    end
    step(32'h30004, 0, 8'h00);
    check8("ctrl_read_full", bus.mem_dout, 8'h01);
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check8("drain_order", tx_data, 8'h50 + 8'(i));
      step(32'h0, 0, 8'h00);
      if (i == 0) check8("full_drop", {7'b0, bus.io_buffer_full}, 8'h00);
    end
    check8("drained", {7'b0, tx_valid}, 8'h00);

    // overflow, then push-while-full with pop
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) step(32'h30000, 1, 8'h60 + 8'(i));
    check8("no_ovf_yet", {7'b0, tx_overflow}, 8'h00);
    step(32'h30000, 1, 8'h70);
    check8("ovf_set", {7'b0, tx_overflow}, 8'h01);
    check8("ovf_head", tx_data, 8'h60);
    tx_ready = 1'b1;
    step(32'h30000, 1, 8'h71);
    check8("push_pop_full_head", tx_data, 8'h61);
    check8("push_pop_full_flag", {7'b0, bus.io_buffer_full}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      e = (i < 7) ? 8'h61 + 8'(i) : 8'h71;
      check8("ovf_drain", tx_data, e);
      step(32'h0, 0, 8'h00);
    end
    check8("ovf_drained", {7'b0, tx_valid}, 8'h00);

    // UART receive
    rx_data = 8'h3C; rx_valid = 1'b1;
    step(32'h30000, 0, 8'h00);
    check8("rx_data", bus.mem_dout, 8'h3C);
    check8("rx_ack_hi", {7'b0, rx_ack}, 8'h01);
    rx_valid = 1'b0;
    step(32'h10, 0, 8'h00);
    check8("rx_ack_lo", {7'b0, rx_ack}, 8'h00);
    step(32'h30000, 0, 8'h00);
    check8("rx_empty_data", bus.mem_dout, 8'h00);
    check8("rx_empty_ack", {7'b0, rx_ack}, 8'h00);
    step(32'h10, 0, 8'h00);
    step(32'h30008, 1, 8'hEE);
    step(32'h30008, 0, 8'h00);
    check8("io_other", bus.mem_dout, 8'h00);

    // halt and reset
    step(32'h30004, 1, 8'h00);
    check8("halt_set", {7'b0, halt}, 8'h01);
    step(32'h20, 1, 8'h5A);
    step(32'h20, 0, 8'h00);
    check8("traffic_read", bus.mem_dout, 8'h5A);
    check8("halt_sticky", {7'b0, halt}, 8'h01);
    rst = 1'b1;
    step(32'h0, 0, 8'h00);
    rst = 1'b0;
    check8("rst2_halt", {7'b0, halt}, 8'h00);
    check8("rst2_ovf", {7'b0, tx_overflow}, 8'h00);
    check8("rst2_dout", bus.mem_dout, 8'h00);
    step(32'h10, 0, 8'h00);
    check8("ram_survives_rst", bus.mem_dout, 8'hA5);

    // rdy=0 freezes state
    tx_ready = 1'b0;
    step(32'h30000, 1, 8'h99);
    step(32'h10, 0, 8'h00);
    rdy = 1'b0;
    step(32'h10, 1, 8'hFF);
    step(32'h30000, 1, 8'h98);
    step(32'h11, 0, 8'h00);
    check8("rdy0_dout_held", bus.mem_dout, 8'hA5);
    rdy = 1'b1;
    step(32'h10, 0, 8'h00);
    check8("rdy0_no_write", bus.mem_dout, 8'hA5);
    check8("rdy0_head", tx_data, 8'h99);
    tx_ready = 1'b1;
    step(32'h0, 0, 8'h00);
    check8("rdy0_no_push", {7'b0, tx_valid}, 8'h00);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      rdy      = ($urandom_range(0, 9) != 0);
      tx_ready = ((c / 200) % 2 == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      case ($urandom_range(0, 7))
        0, 1, 2: a = 32'($urandom_range(0, 31));
        3:       a = 32'h20000 | 32'($urandom_range(0, 31));
        4, 5:    a = 32'h30000;
        6:       a = 32'h30004;
        default: a = ($urandom_range(0, 1) == 0) ? 32'h0 : (32'h30000 | 32'($urandom_range(1, 16'hFFFF)));
      endcase
      a[31:18] = 14'($urandom);
      step(a, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
